rbin_stream_initiator: RTL

- Event-level driver and transmitter for the LSF r-bin histogram accumulator.
- Per event it does three things in order:
  - holds reset_rbins long enough to clear all RBINS histogram bins;
  - converts incoming hit radii into bin indices and streams them on r_bin_V with enable_V high;
  - holds enable_V through the accumulator pipeline latency, then flags the event as done.
- Sits between the hit-radius source and the histogram/local-max block.

---
 rtl/rbin_stream_if.sv | 28 ++
 rtl/rbin_stream_initiator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rbin_stream_if.sv
// rbin_stream_if
//   Groups the two AXI-stream style links handled by rbin_stream_initiator:
//   the incoming hit-radius stream (hit_r_*) and the outgoing bin-index
//   stream (r_bin_V_*).
//   master : used by rbin_stream_initiator. It consumes hits and produces bins.
//   slave  : the opposite view, for the hit source and the histogram sink.
interface rbin_stream_if #(
  parameter int W_r            = 16,
  parameter int W_bin_number_a = 7
);
  logic [W_r-1:0]            hit_r_TDATA;
  logic                      hit_r_TVALID;
  logic                      hit_r_TLAST;
  logic                      hit_r_TREADY;
  logic [W_bin_number_a-1:0] r_bin_V_TDATA;
  logic                      r_bin_V_TVALID;
  logic                      r_bin_V_TREADY;

  modport master (
    input  hit_r_TDATA, hit_r_TVALID, hit_r_TLAST, r_bin_V_TREADY,
    output hit_r_TREADY, r_bin_V_TDATA, r_bin_V_TVALID
  );

  modport slave (
    output hit_r_TDATA, hit_r_TVALID, hit_r_TLAST, r_bin_V_TREADY,
    input  hit_r_TREADY, r_bin_V_TDATA, r_bin_V_TVALID
  );
endinterface

// File: rtl/rbin_stream_initiator.sv
// rbin_stream_initiator
//   Event-level driver for the r-bin histogram accumulator. For each event it
//   clears the histogram (reset_rbins), streams the bin index of every
//   in-range hit radius with enable_V high, keeps enable_V high for the
//   accumulator pipeline latency, then pulses event_done.
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   event_start     : start pulse, only honoured while idle
//   r_offset        : radius of bin 0, captured with an accepted event_start
//   s (master)      : hit_r_* input stream, r_bin_V_* output stream
//   reset_rbins     : histogram clear request (CLEAR phase)
//   enable_V        : histogram accumulate enable (STREAM and DRAIN phases)
//   event_done      : one-cycle pulse when the event has fully drained
//   hit_count       : in-range hits of the current/last event, saturating
//   drop_count      : out-of-range hits of the current/last event, saturating
module rbin_stream_initiator #(
  parameter int RBINS          = 128,
  parameter int W_bin_number_a = 7,
  parameter int W_r            = 16,
  parameter int R_SHIFT        = 4,
  parameter int DRAIN_CYCLES   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           event_start,
  input  logic [W_r-1:0] r_offset,
  rbin_stream_if.master  s,
  output logic           reset_rbins,
  output logic           enable_V,
  output logic           event_done,
  output logic [7:0]     hit_count,
  output logic [7:0]     drop_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // The clear phase is two cycles longer than the bin count so the sink's
  // own clear counter is guaranteed to have swept every bin.
  localparam int              CLR_W    = $clog2(RBINS + 2);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RBINS + 1);
  localparam int              DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [W_r-1:0]  RBINS_CMP = W_r'(RBINS);

  logic [2:0]                state_q, state_d;
  logic [W_r-1:0]            offset_q, offset_d;
  logic [CLR_W-1:0]          clr_cnt_q, clr_cnt_d;
  logic [DRN_W-1:0]          drn_cnt_q, drn_cnt_d;
  logic                      last_seen_q, last_seen_d;
  logic                      tvalid_q, tvalid_d;
  logic [W_bin_number_a-1:0] tdata_q, tdata_d;
  logic [7:0]                hit_cnt_q, hit_cnt_d;
  logic [7:0]                drop_cnt_q, drop_cnt_d;

  logic           hit_ready;
  logic           hit_acc;
  logic           out_acc;
  logic [W_r-1:0] diff;
  logic [W_r-1:0] shifted;
  logic           in_range;

  // A hit can be taken when the output register is empty or being emptied
  // this cycle; after the TLAST hit nothing more is taken for this event.
  assign hit_ready = (state_q == S_STREAM) && !last_seen_q &&
                     (!tvalid_q || s.r_bin_V_TREADY);
  assign hit_acc   = hit_ready && s.hit_r_TVALID;
  assign out_acc   = tvalid_q && s.r_bin_V_TREADY;

  // Hits below the offset would wrap in diff, so they are excluded explicitly.
  assign diff     = s.hit_r_TDATA - offset_q;
  assign shifted  = diff >> R_SHIFT;
  assign in_range = (s.hit_r_TDATA >= offset_q) && (shifted < RBINS_CMP);

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    clr_cnt_d   = clr_cnt_q;
    drn_cnt_d   = drn_cnt_q;
    last_seen_d = last_seen_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    hit_cnt_d   = hit_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (event_start) begin
          offset_d    = r_offset;
          hit_cnt_d   = '0;
          drop_cnt_d  = '0;
          clr_cnt_d   = '0;
          last_seen_d = 1'b0;
          state_d     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = S_STREAM;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      S_STREAM: begin
        if (out_acc) begin
          tvalid_d = 1'b0;
        end
        if (hit_acc) begin
          if (in_range) begin
            tvalid_d = 1'b1;
            tdata_d  = shifted[W_bin_number_a-1:0];
            if (hit_cnt_q != 8'hFF) begin
              hit_cnt_d = hit_cnt_q + 8'd1;
            end
          end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
          end
          if (s.hit_r_TLAST) begin
            last_seen_d = 1'b1;
          end
        end
        // Leave as soon as the final beat is gone, including the cycle in
        // which the sink takes it.
        if (last_seen_q && (!tvalid_q || out_acc)) begin
          drn_cnt_d = '0;
          state_d   = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (drn_cnt_q == DRN_LAST) begin
          state_d = S_DONE;
        end else begin
          drn_cnt_d = drn_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      offset_q    <= '0;
      clr_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      last_seen_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      hit_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      clr_cnt_q   <= clr_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      last_seen_q <= last_seen_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      hit_cnt_q   <= hit_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Phase outputs decode straight from the state register, so they are
  // mutually exclusive and drop to zero the moment reset is applied.
  assign reset_rbins      = (state_q == S_CLEAR);
  assign enable_V         = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign event_done       = (state_q == S_DONE);
  assign s.hit_r_TREADY   = hit_ready;
  assign s.r_bin_V_TVALID = tvalid_q;
  assign s.r_bin_V_TDATA  = tdata_q;
  assign hit_count        = hit_cnt_q;
  assign drop_count       = drop_cnt_q;

endmodule
